// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the sequential ALU.
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_DIV  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// The first iteration is folded into the start cycle so the result is ready WIDTH cycles after start.
module alu_iter_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_q, sh_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, mode_q;

  logic [WIDTH-1:0] src_acc, src_sh, src_b;
  logic             src_mode;
  logic [WIDTH:0]   mul_sum, div_trial;
  logic [WIDTH-1:0] nxt_acc, nxt_sh;

  // mode=1 divides: acc is the partial remainder, sh shifts the dividend out and the quotient in
  always_comb begin
    src_acc   = start ? '0 : acc_q;
    src_sh    = start ? a : sh_q;
    src_b     = start ? b : b_q;
    src_mode  = start ? mode : mode_q;
    mul_sum   = {1'b0, src_acc} + (src_sh[0] ? {1'b0, src_b} : '0);
    div_trial = {src_acc, src_sh[WIDTH-1]} - {1'b0, src_b};
    nxt_acc   = mul_sum[WIDTH:1];
    nxt_sh    = {mul_sum[0], src_sh[WIDTH-1:1]};
    if (src_mode) begin
      if (!div_trial[WIDTH]) begin
        nxt_acc = div_trial[WIDTH-1:0];
        nxt_sh  = {src_sh[WIDTH-2:0], 1'b1};
      end else begin
        nxt_acc = {src_acc[WIDTH-2:0], src_sh[WIDTH-1]};
        nxt_sh  = {src_sh[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      sh_q   <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc_q  <= nxt_acc;
        sh_q   <= nxt_sh;
        b_q    <= b;
        mode_q <= mode;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        acc_q <= nxt_acc;
        sh_q  <= nxt_sh;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 2)) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign lo = sh_q;
  assign hi = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered results, iterative MUL/DIV and a tri-stateable low result bus.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             oe,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_dbz
);

  state_e state_q, state_d;
  op_e    op_in, op_q;

  logic             accept, iter_op;
  logic             md_done;
  logic [WIDTH-1:0] md_lo, md_hi;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] sc_lo, sc_hi;
  logic             sc_carry, sc_ovf, sc_dbz;

  assign op_in    = op_e'(op);
  assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign iter_op  = (op_in == OP_MUL) | ((op_in == OP_DIV) & (b != '0));

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept & iter_op),
    .mode  (op_in == OP_DIV),
    .a     (a),
    .b     (b),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi)
  );

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // The DIV arm only matters for b==0; a non-zero divisor goes to the iterative unit
  always_comb begin
    sc_lo    = '0;
    sc_hi    = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_dbz   = 1'b0;
    case (op_in)
      OP_ADD: begin
        sc_lo    = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_lo    = diff[WIDTH-1:0];
        sc_carry = diff[WIDTH];
        sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_DIV: begin
        sc_lo  = '1;
        sc_hi  = a;
        sc_dbz = 1'b1;
      end
      OP_AND:  sc_lo = a & b;
      OP_OR:   sc_lo = a | b;
      OP_XOR:  sc_lo = a ^ b;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = iter_op ? ST_BUSY : ST_DONE;
      ST_BUSY: if (md_done) state_d = ST_DONE;
      ST_DONE: begin
        if (accept)         state_d = iter_op ? ST_BUSY : ST_DONE;
        else if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      if (accept) op_q <= op_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      result_hi  <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
      flag_dbz   <= 1'b0;
    end else if (accept && !iter_op) begin
      result_q   <= sc_lo;
      result_hi  <= sc_hi;
      flag_zero  <= (sc_lo == '0);
      flag_carry <= sc_carry;
      flag_ovf   <= sc_ovf;
      flag_dbz   <= sc_dbz;
    end else if ((state_q == ST_BUSY) && md_done) begin
      result_q   <= md_lo;
      result_hi  <= md_hi;
      flag_zero  <= (md_lo == '0);
      flag_carry <= (op_q == OP_MUL) && (md_hi != '0);
      flag_ovf   <= (op_q == OP_MUL) && (md_hi != '0);
      flag_dbz   <= 1'b0;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign result    = oe ? result_q : {WIDTH{1'bz}};

endmodule
